pseudo_pll: RTL and testbench
=============================

PSEUDO_PLL -- requirements
Module: pseudo_pll

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of freq_param and of the internal half-period counter.
REQ-002 Port: clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: freq_param  input  WIDTH  requested half-period N in clk_in cycles; 0 = output disabled.
REQ-005 Port: clk_out  output  1  generated clock, registered, glitch-free.
REQ-006 Port: locked  output  1  lock indicator, registered.

Function
REQ-007 clk_out frequency SHALL be f(clk_in)/(2*N), 50% duty, each high and low phase exactly N clk_in cycles.
REQ-008 Internal registers: n_active (WIDTH), cnt (WIDTH), clk_out, lock_cnt (2 bits), locked.
REQ-009 While n_active==0: each edge loads n_active<=freq_param, cnt<=0, clk_out held 0.
REQ-010 While n_active!=0: cnt increments each edge; when cnt==n_active-1 ("boundary"), cnt<=0 and n_active<=freq_param.
REQ-011 At a boundary with freq_param!=0, clk_out SHALL toggle.
REQ-012 At a boundary with freq_param==0, clk_out SHALL go to 0 and stay 0 (REQ-009 applies).
REQ-013 freq_param changes SHALL take effect only at a boundary; the current half-phase always completes with the old N.
REQ-014 N=1: clk_out toggles every clk_in edge (f/2); N=2^WIDTH-1 maximum; cnt never wraps past n_active-1.
REQ-015 First clk_out rising edge SHALL occur on the (N+1)th clk_in rising edge after rst_n deassertion (one load cycle plus N counting cycles).
REQ-016 Lock (when compiled in): at each boundary where clk_out rises and freq_param==n_active, lock_cnt saturates-increments; locked<=1 when lock_cnt reaches 2.
REQ-017 Any boundary with freq_param!=n_active, or n_active==0, SHALL clear lock_cnt and locked in the same edge.

Reset
REQ-018 rst_n low SHALL immediately (asynchronously) force clk_out=0, locked=0, cnt=0, n_active=0, lock_cnt=0.
REQ-019 Reset asserted mid-phase SHALL truncate the phase with no further clk_out edges until the REQ-015 sequence restarts after release.

Configuration
REQ-020 Macro PSEUDO_PLL_LOCK_EN defined: lock_cnt logic and REQ-016/017 behaviour compiled in.
REQ-021 PSEUDO_PLL_LOCK_EN undefined: lock logic omitted; locked SHALL be driven constant 0; clk_out behaviour unchanged.

Verification
REQ-022 freq_param=100, release rst_n -> first clk_out rise at clk_in edge 101, then period 200 clk_in cycles, high 100/low 100.
REQ-023 freq_param=1 -> clk_out = clk_in/2; freq_param=0 -> clk_out constant 0, locked 0.
REQ-024 Change freq_param 100->50 mid-high-phase -> current phase still 100 cycles, following phases 50 cycles.
REQ-025 With PSEUDO_PLL_LOCK_EN, stable freq_param=10 -> locked=1 at second clk_out rising boundary; change to 20 -> locked=0 at next boundary.
REQ-026 Assert rst_n low mid-phase (N=100) -> clk_out and locked 0 immediately, no clock edge needed; after release REQ-022 timing repeats.

Source files
------------

// File: rtl/pseudo_pll.sv
// pseudo_pll -- divides clk_in down to a 50% duty clk_out whose high and low
// phases are each freq_param clk_in cycles long. freq_param is only sampled
// at a half-phase boundary, so a phase in progress always completes with the
// half-period it started with. freq_param == 0 parks clk_out low.
//
// Optional feature: define PSEUDO_PLL_LOCK_EN to build the lock detector,
// which raises `locked` after two consecutive rising boundaries that see an
// unchanged freq_param. Without the macro `locked` is tied low.
module pseudo_pll #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] freq_param,
  output logic             clk_out,
  output logic             locked
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] n_active_q, n_active_d;
  logic [WIDTH-1:0] cnt_q,      cnt_d;
  logic             clk_out_q,  clk_out_d;
  logic             idle;
  logic             boundary;

  // Phase tracking: identify idle state and the last cycle of a half-phase.
  always_comb begin
    idle     = (n_active_q == '0);
    boundary = !idle && (cnt_q == (n_active_q - ONE));
  end

  // Next-state for the divider: load when idle, count, or turn over at a boundary.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    n_active_d = n_active_q;
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    if (idle) begin
      n_active_d = freq_param;
      cnt_d      = '0;
      clk_out_d  = 1'b0;
    end else if (boundary) begin
      n_active_d = freq_param;
      cnt_d      = '0;
      clk_out_d  = (freq_param != '0) ? !clk_out_q : 1'b0;
    end else begin
      cnt_d      = cnt_q + ONE;
    end
  end

  // Divider state registers; reset parks the output low immediately.
  always_ff @(posedge clk_in or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (!rst_n) begin
      n_active_q <= '0;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
    end else begin
      n_active_q <= n_active_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

`ifdef PSEUDO_PLL_LOCK_EN
  logic [1:0] lock_cnt_q, lock_cnt_d;
  logic       locked_q,   locked_d;

  // Lock qualification: count rising boundaries with a stable half-period,
  // drop lock on any boundary that sees a new value or when idle.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (idle) begin
      lock_cnt_d = 2'd0;
      locked_d   = 1'b0;
    end else if (boundary) begin
      if (freq_param != n_active_q) begin
        lock_cnt_d = 2'd0;
        locked_d   = 1'b0;
      end else if (!clk_out_q) begin
        lock_cnt_d = (lock_cnt_q >= 2'd2) ? 2'd2 : lock_cnt_q + 2'd1;
        locked_d   = (lock_cnt_d == 2'd2);
      end
    end
  end

  // Lock state registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= 2'd0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pseudo_pll.sv
// tb_pseudo_pll -- scoreboard bench for pseudo_pll. A phase-level reference
// model predicts every change of {clk_out, locked} with the clk_in edge index
// it happens on; a negedge monitor pops and compares on each observed change.
module tb_pseudo_pll;

  localparam int WIDTH = 8;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic [WIDTH-1:0] freq_param = '0;
  logic             clk_out;
  logic             locked;

  pseudo_pll #(.WIDTH(WIDTH)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .freq_param(freq_param),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int   edge_idx;
    logic lvl;
    logic lck;
  } event_t;

  event_t exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     edge_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Reference model: tracks when the current half-phase ends in absolute
  // edge numbers and what the lock detector has seen, per the rules.
  int   m_n, m_end, m_lc;
  logic m_lvl, m_lock;

  task automatic model_reset();
    edge_no = 0; m_n = 0; m_end = 0; m_lc = 0; m_lvl = 1'b0; m_lock = 1'b0;
  endtask

  task automatic model_step(input int fp);
    logic p_lvl, p_lock;
    p_lvl  = m_lvl;
    p_lock = m_lock;
    edge_no++;
    if (m_n == 0) begin
      m_n = fp; m_end = edge_no + fp; m_lvl = 1'b0; m_lc = 0; m_lock = 1'b0;
    end else if (edge_no == m_end) begin
`ifdef PSEUDO_PLL_LOCK_EN
      if (fp != m_n) begin
        m_lc = 0; m_lock = 1'b0;
      end else if (!m_lvl) begin
        m_lc = (m_lc < 2) ? m_lc + 1 : 2;
        if (m_lc == 2) m_lock = 1'b1;
      end
`endif
      m_n = fp;
      if (fp != 0) begin
        m_lvl = !m_lvl; m_end = edge_no + fp;
      end else begin
        m_lvl = 1'b0;
      end
    end
    if (m_lvl != p_lvl || m_lock != p_lock)
      exp_q.push_back('{edge_idx: edge_no, lvl: m_lvl, lck: m_lock});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step(int'(freq_param));
    end
  end

  // Monitor: every change of the outputs must match the next predicted event.
  initial begin
    logic pl, plk;
    event_t e;
    pl = 1'b0; plk = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        pl = 1'b0; plk = 1'b0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].edge_idx < edge_no) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_event: no change seen, expected clk_out=%0b locked=%0b at edge %0d",
                   e.lvl, e.lck, e.edge_idx);
        end
        if (clk_out !== pl || locked !== plk) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: clk_out=%0b locked=%0b at edge %0d, none expected",
                     clk_out, locked, edge_no);
          end else begin
            e = exp_q.pop_front();
            check("event_edge",   edge_no, e.edge_idx);
            check("event_clkout", clk_out, e.lvl);
            check("event_locked", locked,  e.lck);
          end
          pl = clk_out; plk = locked;
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_high(input string name);
    for (int i = 0; i < 600 && clk_out !== 1'b1; i++) @(negedge clk_in);
    check(name, clk_out, 1'b1);
  endtask

  task automatic async_reset(input string name);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_clkout"}, clk_out, 1'b0);
    check({name, "_locked"}, locked,  1'b0);
    run(3);
    rst_n = 1'b1;
  endtask

  initial begin
    freq_param = 8'd100;
    run(2);
    check("reset_clkout", clk_out, 1'b0);
    check("reset_locked", locked,  1'b0);
    rst_n = 1'b1;

    // N=100: rise at edge 101, then 100/100 phases; switch to 50 mid-high.
    run(350);
    check("high_before_change", clk_out, 1'b1);
    freq_param = 8'd50;
    run(300);

    // f/2, disabled, lock at 10, relock lost at 20.
    freq_param = 8'd1;   run(20);
    freq_param = 8'd0;   run(30);
    check("disabled_clkout", clk_out, 1'b0);
    check("disabled_locked", locked,  1'b0);
    freq_param = 8'd10;  run(100);
    freq_param = 8'd20;  run(80);

    // Reset in the middle of a high phase, then the start-up sequence again.
    freq_param = 8'd100;
    wait_high("reach_high");
    async_reset("mid_reset");
    run(450);

    // Maximum half-period.
    freq_param = 8'd255;
    run(800);

    // Randomized half-periods and hold times.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) freq_param = 8'($urandom_range(0, 255));
      else                           freq_param = 8'($urandom_range(0, 12));
      run($urandom_range(1, 80));
      if ($urandom_range(0, 15) == 0) async_reset("rand_reset");
    end
    run(5);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
